dmem_bus_ctrl: RTL and testbench

//  Data-memory bus controller between the memory-stage load/store unit and data memory/bus.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_bus_ctrl_if.sv | 26 ++
 rtl/dmem_timeout_cnt.sv | 36 +++
 rtl/dmem_bus_ctrl.sv | 126 ++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_BE_W   = DMEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } dmem_state_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_BE_W-1:0]   mask;
  } dmem_req_t;

  localparam logic [DMEM_BE_W-1:0] BE_ALL = '1;

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Data-memory bus: req/gnt request phase plus rvalid/rdata response phase.
interface dmem_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_W-1:0]     bus_addr_o;
  logic [DATA_W-1:0]     bus_wdata_o;
  logic [DATA_W/8-1:0]   bus_be_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [DATA_W-1:0]     bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// Bus-wait cycle counter; expired_o flags the cycle in which the count reaches TIMEOUT_CYC.
module dmem_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The increment at this edge would make the count equal TIMEOUT_CYC.
  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Memory-stage load/store bus controller: one request at a time, stalls until done.
// Optional bus-wait timeout enabled with DMEM_TIMEOUT_EN.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_mask_i,
  output logic                stall_o,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   data_loaded_o,
  output logic                err_o,
  dmem_bus_ctrl_if.master     bus
);

  dmem_state_e       state_q, state_d;
  dmem_req_t         req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              bus_req_q, bus_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              empty_store;

  assign empty_store = req_we_i && (req_mask_i == '0);

`ifdef DMEM_TIMEOUT_EN
  logic to_clr, to_en, to_expired;

  assign to_clr = (state_q == IDLE) && req_valid_i && !empty_store;
  assign to_en  = (state_q == REQ) || (state_q == WAIT);

  dmem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d.we    = req_we_i;
          req_d.addr  = {req_addr_i[ADDR_W-1:2], 2'b00};
          req_d.wdata = req_wdata_i;
          req_d.mask  = req_we_i ? req_mask_i : BE_ALL;
          state_d     = empty_store ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.bus_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid_i) begin
          state_d = DONE;
          if (!req_q.we) begin
            data_d = bus.bus_rdata_i;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef DMEM_TIMEOUT_EN
    // A genuine response arriving in the expiring cycle takes precedence.
    if (to_expired && (state_d != DONE)) begin
      state_d = DONE;
      err_d   = 1'b1;
      if (!req_q.we) begin
        data_d = '0;
      end
    end
`endif
    bus_req_d   = (state_d == REQ);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign stall_o       = ((state_q == IDLE) && req_valid_i) || (state_q == REQ) || (state_q == WAIT);
  assign rsp_valid_o   = rsp_valid_q;
  assign err_o         = err_q;
  assign data_loaded_o = data_q;

  // Bus fields are only presented while the request is outstanding.
  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_req_q ? req_q.we    : 1'b0;
  assign bus.bus_addr_o  = bus_req_q ? req_q.addr  : '0;
  assign bus.bus_wdata_o = bus_req_q ? req_q.wdata : '0;
  assign bus.bus_be_o    = bus_req_q ? req_q.mask  : '0;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed scenarios plus randomized transactions.
module tb_dmem_bus_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_mask_i = '0;
  logic        stall_o, rsp_valid_o, err_o;
  logic [31:0] data_loaded_o;

  int tests = 0;
  int fails = 0;
  int total_grants = 0;
  logic [31:0] model_loaded = '0;

  dmem_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  dmem_bus_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_mask_i    (req_mask_i),
    .stall_o       (stall_o),
    .rsp_valid_o   (rsp_valid_o),
    .data_loaded_o (data_loaded_o),
    .err_o         (err_o),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_rsp"}, rsp_valid_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_breq"}, bus_if.bus_req_o, 0);
    check({tag, "_bwe"}, bus_if.bus_we_o, 0);
    check({tag, "_baddr"}, bus_if.bus_addr_o, 0);
    check({tag, "_bwdata"}, bus_if.bus_wdata_o, 0);
    check({tag, "_bbe"}, bus_if.bus_be_o, 0);
  endtask

  // One load/store from the memory stage, with a bus slave granting after gnt_dly
  // request cycles and responding after rv_dly wait cycles; rvalid noise elsewhere.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int gnt_dly, input int rv_dly,
                     input logic [31:0] rdata, input bit expect_to);
    int stalls = 0, reqs = 0, grants = 0, waits = 0, cyc = 0;
    int exp_stalls, exp_reqs, exp_grants;
    bit granted = 0, done = 0, empty;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    empty    = we && (mask == 4'h0);
    exp_addr = addr & 32'hFFFF_FFFC;
    exp_be   = we ? mask : 4'hF;
    if (empty) begin
      exp_stalls = 1; exp_reqs = 0; exp_grants = 0;
    end else if (expect_to) begin
      exp_stalls = 1 + TO; exp_reqs = TO; exp_grants = 0;
    end else begin
      exp_stalls = 3 + gnt_dly + rv_dly; exp_reqs = gnt_dly + 1; exp_grants = 1;
    end
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wdata; req_mask_i = mask;
    bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0;
    while (!done && cyc < 200) begin
      #1;
      cyc++;
      if (stall_o) stalls++;
      bus_if.bus_gnt_i    = 1'b0;
      bus_if.bus_rvalid_i = 1'($urandom_range(0, 1));
      bus_if.bus_rdata_i  = $urandom;
      if (rsp_valid_o) begin
        done = 1;
        if (!empty && !we) model_loaded = expect_to ? 32'h0 : rdata;
        check("rsp_err", err_o, expect_to ? 1 : 0);
        check("rsp_data", data_loaded_o, model_loaded);
      end else if (!granted) begin
        if (bus_if.bus_req_o) begin
          reqs++;
          check("req_we", bus_if.bus_we_o, we);
          check("req_addr", bus_if.bus_addr_o, exp_addr);
          check("req_be", bus_if.bus_be_o, exp_be);
          if (we) check("req_wdata", bus_if.bus_wdata_o, wdata);
          if (reqs == gnt_dly + 1) begin
            bus_if.bus_gnt_i = 1'b1;
            grants++;
            total_grants++;
            granted = 1;
          end
        end
      end else begin
        check("wait_noreq", bus_if.bus_req_o, 0);
        waits++;
        bus_if.bus_rvalid_i = 1'b0;
        if (waits == rv_dly + 1) begin
          bus_if.bus_rvalid_i = 1'b1;
          bus_if.bus_rdata_i  = rdata;
        end
      end
      if (!done) @(negedge clk);
    end
    check("rsp_seen", done, 1);
    check("stall_cycles", stalls, exp_stalls);
    check("req_cycles", reqs, exp_reqs);
    check("grants", grants, exp_grants);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    bus_if.bus_gnt_i = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    check("rsp_pulse", rsp_valid_o, 0);
    check("err_clear", err_o, 0);
  endtask

  initial begin
    bus_if.bus_gnt_i = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    bus_if.bus_rdata_i = '0;
    #12;
    check_quiet("reset");
    check("reset_data", data_loaded_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load, zero wait states.
    txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0);
    check("t1_data", data_loaded_o, 32'hDEAD_BEEF);
    // Byte store, grant delayed two cycles; loaded word unaffected.
    txn(1'b1, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 2, 0, 32'h1234_5678, 0);
    check("t2_data", data_loaded_o, 32'hDEAD_BEEF);
    // Empty store: no bus cycle.
    txn(1'b1, 32'h0000_0300, 32'h5555_5555, 4'b0000, 0, 0, 32'h0, 0);
    // Back-to-back load then store.
    total_grants = 0;
    txn(1'b0, 32'h0000_0400, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D, 0);
    txn(1'b1, 32'h0000_0404, 32'h0102_0304, 4'b0011, 0, 2, 32'h0, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("b2b_idle_req", bus_if.bus_req_o, 0);
    end
    check("b2b_grants", total_grants, 2);

    // Reset while waiting for the response, then a stray rvalid.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_0500;
    @(negedge clk); #1;
    check("rst_req", bus_if.bus_req_o, 1);
    bus_if.bus_gnt_i = 1'b1;
    @(negedge clk); #1;
    bus_if.bus_gnt_i = 1'b0;
    check("rst_wait_stall", stall_o, 1);
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    #1;
    check_quiet("rst_mid");
    check("rst_mid_data", data_loaded_o, 0);
    model_loaded = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i = 32'hBAD0_BAD0;
    repeat (2) begin
      @(negedge clk); #1;
      check_quiet("stray_rvalid");
      check("stray_data", data_loaded_o, 0);
    end
    bus_if.bus_rvalid_i = 1'b0;

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      logic        we;
      logic [3:0]  mask;
      we   = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      txn(we, $urandom, $urandom, mask, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
    end

`ifdef DMEM_TIMEOUT_EN
    txn(1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 0, 32'h7777_7777, 0);
    check("to_pre_data", data_loaded_o, 32'h7777_7777);
    txn(1'b0, 32'h0000_0700, 32'h0, 4'h0, 1000, 0, 32'h0, 1);
    check("to_data", data_loaded_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
